axi_read_master_v2: RTL and testbench

- Next-generation AXI4 read master: moves a byte-exact region from memory to an AXI4-Stream.
- Accepts beat-aligned, non-burst-aligned start addresses. Splits bursts at 4 KB boundaries and at max burst length.
- Drives TKEEP on the final beat; asserts TLAST once per command.
- Sits between a kernel control block and a compute stream, like the existing read masters.

---
 rtl/axi_read_master_v2_pkg.sv | 34 +++
 rtl/axi_master_counter.sv | 28 ++
 rtl/axi_rd_burst_calc.sv | 32 +++
 rtl/axi_read_master_v2.sv | 187 ++++++++++++++++++
 tb/tb_axi_read_master_v2.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_read_master_v2_pkg.sv
// Shared types, constants and helpers for the AXI4 read master.
package axi_read_master_v2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int LP_4K_BYTES  = 4096;
  localparam int LP_4K_ADDR_W = 12;

  function automatic logic [63:0] f_min(input logic [63:0] a, input logic [63:0] b);
    return (a < b) ? a : b;
  endfunction

  // Byte-index width within one data beat.
  function automatic int f_byte_idx_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Wide enough for ceil(max_len / DWB).
  function automatic int f_beats_w(input int xfer_w, input int dw);
    return xfer_w - $clog2(dw / 8) + 1;
  endfunction

  // Holds burst lengths 1..max_burst inclusive.
  function automatic int f_burst_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/axi_master_counter.sv
// Generic load/up/down counter shared by the read masters.
module axi_master_counter #(
  parameter int                 C_WIDTH = 8,
  parameter logic [C_WIDTH-1:0] C_INIT  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_value,
  input  logic               incr,
  input  logic               decr,
  output logic [C_WIDTH-1:0] count
);

  // Simultaneous incr and decr cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= C_INIT;
    end else if (load) begin
      count <= load_value;
    end else if (incr && !decr) begin
      count <= count + C_WIDTH'(1);
    end else if (decr && !incr) begin
      count <= count - C_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_rd_burst_calc.sv
// Registered burst length: min(max burst, beats left in the 4 KB page, remaining beats).
module axi_rd_burst_calc
  import axi_read_master_v2_pkg::*;
#(
  parameter int C_MAX_BURST_LENGTH = 64,
  parameter int C_IDX_W            = 6,
  parameter int C_BEATS_W          = 27,
  parameter int C_BURST_W          = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [LP_4K_ADDR_W-1:0] addr_lo,
  input  logic [C_BEATS_W-1:0]    remaining,
  output logic [C_BURST_W-1:0]    burst
);

  logic [LP_4K_ADDR_W:0] to_4k_bytes;

  // The address is beat aligned, so the page remainder divides exactly.
  assign to_4k_bytes = (LP_4K_ADDR_W + 1)'(LP_4K_BYTES) - {1'b0, addr_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      burst <= '0;
    end else if (en) begin
      burst <= C_BURST_W'(f_min(f_min(64'(C_MAX_BURST_LENGTH), 64'(to_4k_bytes >> C_IDX_W)),
                                64'(remaining)));
    end
  end

endmodule

// File: rtl/axi_read_master_v2.sv
// AXI4 read master streaming a byte-exact region to AXI4-Stream.
// Optional RRESP error flag: define AXI_READ_MASTER_V2_RRESP_CHECK_EN.
module axi_read_master_v2
  import axi_read_master_v2_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_OUTSTANDING  = 16,
  parameter int C_MAX_BURST_LENGTH = 64
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  output logic                            ctrl_ready,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                            m_axi_rlast,
  input  logic [1:0]                      m_axi_rresp,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            ctrl_error
);

  localparam int LP_DWB     = C_M_AXI_DATA_WIDTH / 8;
  localparam int LP_IDX_W   = f_byte_idx_w(C_M_AXI_DATA_WIDTH);
  localparam int LP_BEATS_W = f_beats_w(C_XFER_SIZE_WIDTH, C_M_AXI_DATA_WIDTH);
  localparam int LP_BURST_W = f_burst_w(C_MAX_BURST_LENGTH);
  localparam int LP_VAC_W   = $clog2(C_MAX_OUTSTANDING + 1);

  state_t                        state, state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_r;
  logic [LP_BEATS_W-1:0]         remaining_r;
  logic [LP_BEATS_W-1:0]         beats_in;
  logic [LP_BEATS_W-1:0]         beat_cnt;
  logic [LP_DWB-1:0]             last_keep_r;
  logic [LP_DWB-1:0]             keep_in;
  logic [LP_BURST_W-1:0]         burst;
  logic [LP_VAC_W-1:0]           vacancy;
  logic [C_XFER_SIZE_WIDTH:0]    len_round;
  logic                          done_r;
  logic                          start_ok;
  logic                          ar_hs;
  logic                          r_hs;
  logic                          final_beat;
  logic                          unused_bits;

  assign start_ok   = ctrl_start && (state == IDLE);
  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign final_beat = (beat_cnt == LP_BEATS_W'(1));

  assign len_round = {1'b0, ctrl_xfer_size_in_bytes} + (C_XFER_SIZE_WIDTH + 1)'(LP_DWB - 1);
  assign beats_in  = len_round[C_XFER_SIZE_WIDTH:LP_IDX_W];

  // A length that is a whole number of beats keeps every byte of the last beat.
  always_comb begin
    keep_in = '1;
    if (ctrl_xfer_size_in_bytes[LP_IDX_W-1:0] != '0) begin
      keep_in = (LP_DWB'(1) << ctrl_xfer_size_in_bytes[LP_IDX_W-1:0]) - LP_DWB'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (beats_in == '0) ? DONE : CALC;
      CALC:    state_nxt = ISSUE;
      ISSUE:   if (ar_hs) state_nxt = (remaining_r == LP_BEATS_W'(burst)) ? DRAIN : CALC;
      DRAIN:   if ((beat_cnt == '0) || (r_hs && final_beat)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address and remaining beats advance only on an accepted AR.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_r      <= '0;
      remaining_r <= '0;
      last_keep_r <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      if (start_ok) begin
        addr_r      <= {ctrl_addr_offset[C_M_AXI_ADDR_WIDTH-1:LP_IDX_W], LP_IDX_W'(0)};
        remaining_r <= beats_in;
        last_keep_r <= keep_in;
      end else if (ar_hs) begin
        addr_r      <= addr_r + (C_M_AXI_ADDR_WIDTH'(burst) << LP_IDX_W);
        remaining_r <= remaining_r - LP_BEATS_W'(burst);
      end
    end
  end

  axi_rd_burst_calc #(
    .C_MAX_BURST_LENGTH(C_MAX_BURST_LENGTH),
    .C_IDX_W           (LP_IDX_W),
    .C_BEATS_W         (LP_BEATS_W),
    .C_BURST_W         (LP_BURST_W)
  ) u_burst_calc (
    .clk      (aclk),
    .reset    (areset),
    .en       (state == CALC),
    .addr_lo  (addr_r[LP_4K_ADDR_W-1:0]),
    .remaining(remaining_r),
    .burst    (burst)
  );

  axi_master_counter #(
    .C_WIDTH(LP_BEATS_W),
    .C_INIT (LP_BEATS_W'(0))
  ) u_beat_cnt (
    .clk       (aclk),
    .reset     (areset),
    .load      (start_ok),
    .load_value(beats_in),
    .incr      (1'b0),
    .decr      (r_hs && (beat_cnt != '0)),
    .count     (beat_cnt)
  );

  // Free AR slots: returned on each burst's RLAST, consumed on each AR.
  axi_master_counter #(
    .C_WIDTH(LP_VAC_W),
    .C_INIT (LP_VAC_W'(C_MAX_OUTSTANDING))
  ) u_vacancy (
    .clk       (aclk),
    .reset     (areset),
    .load      (1'b0),
    .load_value('0),
    .incr      (r_hs && m_axi_rlast && (vacancy != LP_VAC_W'(C_MAX_OUTSTANDING))),
    .decr      (ar_hs),
    .count     (vacancy)
  );

  assign ctrl_ready    = (state == IDLE);
  assign ctrl_done     = done_r;
  assign m_axi_arvalid = (state == ISSUE) && (vacancy != '0);
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = 8'(burst - LP_BURST_W'(1));
  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tlast  = final_beat;
  assign m_axis_tkeep  = final_beat ? last_keep_r : '1;

`ifdef AXI_READ_MASTER_V2_RRESP_CHECK_EN
  logic error_r;

  always_ff @(posedge aclk) begin
    if (areset) begin
      error_r <= 1'b0;
    end else if (start_ok) begin
      error_r <= 1'b0;
    end else if (r_hs && m_axi_rresp[1]) begin
      error_r <= 1'b1;
    end
  end

  assign ctrl_error  = error_r;
  assign unused_bits = ^{ctrl_addr_offset[LP_IDX_W-1:0], len_round[LP_IDX_W-1:0], m_axi_rresp[0]};
`else
  assign ctrl_error  = 1'b0;
  assign unused_bits = ^{ctrl_addr_offset[LP_IDX_W-1:0], len_round[LP_IDX_W-1:0], m_axi_rresp};
`endif

endmodule

// File: tb/tb_axi_read_master_v2.sv
// Self-checking bench for axi_read_master_v2 (DW=512, two outstanding ARs).
module tb_axi_read_master_v2;

  localparam int MAX_OUT = 2;
`ifdef AXI_READ_MASTER_V2_RRESP_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         ctrl_start = 1'b0;
  logic         ctrl_ready;
  logic         ctrl_done;
  logic [63:0]  ctrl_addr_offset = '0;
  logic [31:0]  ctrl_xfer_size_in_bytes = '0;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [511:0] m_axi_rdata = '0;
  logic         m_axi_rlast = 1'b0;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         ctrl_error;

  axi_read_master_v2 #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_M_AXI_DATA_WIDTH(512),
    .C_XFER_SIZE_WIDTH (32),
    .C_MAX_OUTSTANDING (MAX_OUT),
    .C_MAX_BURST_LENGTH(64)
  ) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .ctrl_start             (ctrl_start),
    .ctrl_ready             (ctrl_ready),
    .ctrl_done              (ctrl_done),
    .ctrl_addr_offset       (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .m_axi_arvalid          (m_axi_arvalid),
    .m_axi_arready          (m_axi_arready),
    .m_axi_araddr           (m_axi_araddr),
    .m_axi_arlen            (m_axi_arlen),
    .m_axi_rvalid           (m_axi_rvalid),
    .m_axi_rready           (m_axi_rready),
    .m_axi_rdata            (m_axi_rdata),
    .m_axi_rlast            (m_axi_rlast),
    .m_axi_rresp            (m_axi_rresp),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tkeep           (m_axis_tkeep),
    .m_axis_tlast           (m_axis_tlast),
    .ctrl_error             (ctrl_error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    int          n_ar;
    int          beats;
    int          tlasts;
    logic [63:0] keep;
  } vec_t;

  // Reference model: expected AR list and expected stream for the current command.
  ar_t         exp_ar[$];
  logic [63:0] exp_base;
  int          exp_beats;
  int          exp_idx;
  logic [63:0] exp_keep;

  // Memory slave state: accepted bursts waiting for data.
  ar_t         slv_q[$];
  int          slv_idx;

  int          outstanding;
  int          ar_seen, tlast_seen, done_seen;
  logic [63:0] last_keep_seen;
  int          ar_mode, r_en, rv_pct, tr_mode, err_beat;
  int          total, bad;

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Splits the region by the rules directly: page end, max burst, bytes left.
  task automatic model_cmd(input logic [63:0] addr, input logic [31:0] len);
    logic [63:0] a;
    longint      rem, b, room;
    a         = addr & ~64'h3F;
    exp_base  = a;
    exp_beats = int'((64'(len) + 64'd63) / 64'd64);
    exp_idx   = 0;
    exp_keep  = ((len % 64) == 0) ? '1 : ((64'h1 << (len % 64)) - 64'h1);
    rem       = exp_beats;
    while (rem > 0) begin
      room = (4096 - longint'(a % 64'd4096)) / 64;
      b = 64;
      if (room < b) b = room;
      if (rem < b) b = rem;
      exp_ar.push_back('{addr: a, len: 8'(b - 1)});
      a   = a + 64'(b * 64);
      rem = rem - b;
    end
  endtask

  // One clock: monitor at negedge, then drive the slave side just after posedge.
  task automatic tick();
    bit          ar_hs, r_hs;
    ar_t         e;
    logic [63:0] beat_addr;
    logic [63:0] k_exp;
    @(negedge aclk);
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid && m_axi_rready;
    if (ar_hs) begin
      ar_seen++;
      check_output("ar_expected", exp_ar.size() > 0, 1);
      if (exp_ar.size() > 0) begin
        e = exp_ar.pop_front();
        check_output("araddr", m_axi_araddr, e.addr);
        check_output("arlen", m_axi_arlen, e.len);
      end
      slv_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
      outstanding++;
      check_output("outstanding_limit", outstanding <= MAX_OUT, 1);
    end
    if (r_hs) begin
      check_output("beat_expected", exp_idx < exp_beats, 1);
      if (exp_idx < exp_beats) begin
        k_exp = (exp_idx == exp_beats - 1) ? exp_keep : '1;
        check_output("tdata", m_axis_tdata, {8{exp_base + 64'(exp_idx) * 64'd64}});
        check_output("tkeep", m_axis_tkeep, k_exp);
        check_output("tlast", m_axis_tlast, exp_idx == exp_beats - 1);
      end
      if (m_axis_tlast) begin
        tlast_seen++;
        last_keep_seen = m_axis_tkeep;
      end
      exp_idx++;
      if (m_axi_rlast) outstanding--;
    end
    if (ctrl_done) done_seen++;
    @(posedge aclk);
    #1;
    if (r_hs && slv_q.size() > 0) begin
      slv_idx++;
      if (slv_idx > int'(slv_q[0].len)) begin
        void'(slv_q.pop_front());
        slv_idx = 0;
      end
    end
    if (!(m_axi_rvalid && !r_hs)) begin
      if (r_en != 0 && slv_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
        beat_addr    = slv_q[0].addr + 64'(slv_idx) * 64'd64;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {8{beat_addr}};
        m_axi_rlast  = (slv_idx == int'(slv_q[0].len));
        m_axi_rresp  = (exp_idx == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
    case (ar_mode)
      0:       m_axi_arready = 1'b0;
      1:       m_axi_arready = 1'b1;
      default: m_axi_arready = ($urandom_range(0, 1) == 1);
    endcase
    m_axis_tready = (tr_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_model();
    exp_ar.delete();
    slv_q.delete();
    exp_beats   = 0;
    exp_idx     = 0;
    slv_idx     = 0;
    outstanding = 0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    ctrl_start = 1'b0;
    clear_model();
    repeat (3) tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic apply_stimulus(input logic [63:0] addr, input logic [31:0] len);
    model_cmd(addr, len);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = len;
    ctrl_start              = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic finish_cmd(input int d0);
    int n;
    n = 0;
    while (done_seen == d0 && n < 5000) begin
      tick();
      n++;
    end
    check_output("done_seen", done_seen != d0, 1);
    repeat (3) tick();
    check_output("done_once", done_seen - d0, 1);
    check_output("ar_all_issued", exp_ar.size(), 0);
    check_output("beats_count", exp_idx, exp_beats);
    check_output("ready_after", ctrl_ready, 1);
  endtask

  task automatic run_cmd(input logic [63:0] addr, input logic [31:0] len);
    int d0;
    d0 = done_seen;
    apply_stimulus(addr, len);
    finish_cmd(d0);
  endtask

  initial begin
    vec_t vecs[7];
    int   d0, a0, t0, n;

    vecs[0] = '{addr: 64'h0,         len: 32'd4096, n_ar: 1, beats: 64,  tlasts: 1, keep: '1};
    vecs[1] = '{addr: 64'hFC0,       len: 32'd256,  n_ar: 2, beats: 4,   tlasts: 1, keep: '1};
    vecs[2] = '{addr: 64'h2000,      len: 32'd100,  n_ar: 1, beats: 2,   tlasts: 1, keep: 64'h0000_000F_FFFF_FFFF};
    vecs[3] = '{addr: 64'h40,        len: 32'd0,    n_ar: 0, beats: 0,   tlasts: 0, keep: 64'h0};
    vecs[4] = '{addr: 64'h1234_0FF3, len: 32'd130,  n_ar: 2, beats: 3,   tlasts: 1, keep: 64'h3};
    vecs[5] = '{addr: 64'hF80,       len: 32'd4480, n_ar: 3, beats: 70,  tlasts: 1, keep: '1};
    vecs[6] = '{addr: 64'h7000,      len: 32'd8192, n_ar: 2, beats: 128, tlasts: 1, keep: '1};

    total = 0; bad = 0;
    ar_seen = 0; tlast_seen = 0; done_seen = 0; last_keep_seen = '0;
    ar_mode = 2; r_en = 1; rv_pct = 70; tr_mode = 0; err_beat = -1;
    do_reset();

    check_output("rst_ready", ctrl_ready, 1);
    check_output("rst_arvalid", m_axi_arvalid, 0);
    check_output("rst_done", ctrl_done, 0);
    check_output("rst_error", ctrl_error, 0);
    check_output("rst_tvalid", m_axis_tvalid, 0);

    // Zero length: done two cycles after start; a start while busy is dropped.
    d0 = done_seen;
    a0 = ar_seen;
    apply_stimulus(64'h100, 32'd0);
    check_output("zl_ready_drop", ctrl_ready, 0);
    check_output("zl_done_early", ctrl_done, 0);
    ctrl_xfer_size_in_bytes = 32'd4096;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check_output("zl_done_2cyc", ctrl_done, 1);
    check_output("zl_ready_back", ctrl_ready, 1);
    repeat (10) tick();
    check_output("zl_no_ar", ar_seen - a0, 0);
    check_output("zl_done_count", done_seen - d0, 1);
    check_output("zl_busy_start_ignored", ctrl_ready, 1);

    for (int i = 0; i < 7; i++) begin
      a0 = ar_seen;
      t0 = tlast_seen;
      last_keep_seen = '0;
      run_cmd(vecs[i].addr, vecs[i].len);
      check_output($sformatf("vec%0d_n_ar", i), ar_seen - a0, vecs[i].n_ar);
      check_output($sformatf("vec%0d_beats", i), exp_idx, vecs[i].beats);
      check_output($sformatf("vec%0d_tlasts", i), tlast_seen - t0, vecs[i].tlasts);
      check_output($sformatf("vec%0d_last_keep", i), last_keep_seen, vecs[i].keep);
    end

    // Outstanding limit: with R withheld only MAX_OUT ARs may go out.
    ar_mode = 1;
    r_en = 0;
    d0 = done_seen;
    a0 = ar_seen;
    apply_stimulus(64'h0, 32'd16384);
    repeat (30) tick();
    check_output("out_ar_count", ar_seen - a0, MAX_OUT);
    check_output("out_arvalid_low", m_axi_arvalid, 0);
    r_en = 1;
    finish_cmd(d0);
    check_output("out_total_ar", ar_seen - a0, 4);
    ar_mode = 2;

    // Error response on beat 3 still lets the command complete.
    err_beat = 2;
    run_cmd(64'h4_0000, 32'd512);
    check_output("err_flag", ctrl_error, EXP_ERR);
    err_beat = -1;
    run_cmd(64'h80, 32'd128);
    check_output("err_cleared", ctrl_error, 0);

    // Reset while an AR is pending aborts the command.
    ar_mode = 0;
    apply_stimulus(64'h3000, 32'd4096);
    n = 0;
    while (!m_axi_arvalid && n < 10) begin
      tick();
      n++;
    end
    check_output("rst_mid_reach_issue", m_axi_arvalid, 1);
    areset = 1'b1;
    tick();
    check_output("rst_mid_arvalid", m_axi_arvalid, 0);
    check_output("rst_mid_ready", ctrl_ready, 1);
    areset = 1'b0;
    clear_model();
    ar_mode = 2;
    tick();

    for (int i = 0; i < 8; i++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      if (i % 2 == 0) ra[11:0] = 12'(12'hE00 + $urandom_range(0, 511));
      rv_pct = $urandom_range(40, 100);
      tr_mode = i % 2;
      run_cmd(ra, 32'($urandom_range(0, 3000)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
